// File: rtl/ap_handshake_profiler.sv
// Profiles ap_ctrl_hs/chain transactions into a latency/interval/stall record FIFO.
// Define PROFILER_STALL_EN to count cycles spent waiting on ap_continue.
module ap_handshake_profiler #(
    parameter int CNT_W      = 32,
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [CNT_W-1:0] rec_stall,
    output logic             rec_incomplete,
    output logic [15:0]      overflow_cnt,
    output logic             drained
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RUN       = 3'd1;
    localparam logic [2:0] WAIT_CONT = 3'd2;
    localparam logic [2:0] FLUSH     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = ID_W + 3 * CNT_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] since_q, since_d;
    logic [CNT_W-1:0] intv_q, intv_d;
    logic             seen_q, seen_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [15:0]      ovf_q, ovf_d;
    logic [PW:0]      wr_q, wr_d;
    logic [PW:0]      rd_q, rd_d;
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];

    logic             push, push_ok, pop, full, empty, rec_inc;
    logic [CNT_W-1:0] stall_rec;
    logic [REC_W-1:0] push_rec, head;

    logic             unused_ready;
    assign unused_ready = ap_ready;

`ifdef PROFILER_STALL_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) stall_q <= '0;
        else           stall_q <= stall_d;
    end

    // The completing WAIT_CONT cycle itself counts as a stall cycle.
    assign stall_rec = (state_q == WAIT_CONT) ? sat_inc(stall_q) : stall_q;
`else
    assign stall_rec = '0;
`endif

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop      = !empty && rec_ready;
    assign push_ok  = push && (!full || pop);
    assign push_rec = {id_q, sat_inc(lat_q), intv_q, stall_rec, rec_inc};

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        since_d = seen_q ? sat_inc(since_q) : since_q;
        intv_d  = intv_q;
        seen_d  = seen_q;
        id_d    = id_q;
        push    = 1'b0;
        rec_inc = 1'b0;
`ifdef PROFILER_STALL_EN
        stall_d = stall_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (finish) begin
                    state_d = FLUSH;
                end else if (ap_start) begin
                    state_d = RUN;
                    lat_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    since_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    intv_d  = seen_q ? since_q : '0;
                    seen_d  = 1'b1;
`ifdef PROFILER_STALL_EN
                    stall_d = '0;
`endif
                end
            end
            RUN: begin
                lat_d = sat_inc(lat_q);
                if (finish) begin
                    push    = 1'b1;
                    rec_inc = 1'b1;
                    state_d = FLUSH;
                end else if (ap_done) begin
                    push    = ap_continue;
                    state_d = ap_continue ? IDLE : WAIT_CONT;
                end
            end
            WAIT_CONT: begin
                lat_d = sat_inc(lat_q);
`ifdef PROFILER_STALL_EN
                stall_d = sat_inc(stall_q);
`endif
                if (finish) begin
                    push    = 1'b1;
                    rec_inc = 1'b1;
                    state_d = FLUSH;
                end else if (ap_continue) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (empty) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (push) id_d = id_q + 1'b1;
    end

    always_comb begin
        wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        ovf_d = ovf_q;
        if (push && !push_ok && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            since_q <= '0;
            intv_q  <= '0;
            seen_q  <= 1'b0;
            id_q    <= '0;
            ovf_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            since_q <= since_d;
            intv_q  <= intv_d;
            seen_q  <= seen_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push_ok) mem_q[wr_q[PW-1:0]] <= push_rec;
    end

    // Stale storage is masked so data outputs read 0 whenever nothing is queued.
    assign head      = empty ? '0 : mem_q[rd_q[PW-1:0]];
    assign rec_valid = !empty;
    assign {rec_id, rec_latency, rec_interval, rec_stall, rec_incomplete} = head;

    assign overflow_cnt = ovf_q;
    assign drained      = (state_q == DONE);

endmodule

// File: doc/ap_handshake_profiler.md
AP_HANDSHAKE_PROFILER -- requirements
Module: ap_handshake_profiler

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of latency/interval/stall counters.
REQ-002 SHALL have parameter ID_W, default 8, transaction ID width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, record FIFO entries (power of 2, >=2).
REQ-004 ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-006 ap_start, ap_ready, ap_done, ap_continue  in  1 each  ap_ctrl_hs/chain handshake of the observed non-dataflow HLS module.
REQ-007 finish  in  1  end-of-simulation request.
REQ-008 rec_valid  out 1; rec_ready  in 1  record stream handshake to the CSV record sink.
REQ-009 rec_id  out ID_W; rec_latency, rec_interval, rec_stall  out CNT_W each; rec_incomplete  out 1.
REQ-010 overflow_cnt  out 16  records dropped on full FIFO; drained  out 1  flush complete.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, WAIT_CONT, FLUSH, DONE.
REQ-012 IDLE: ap_start=1 SHALL mark start cycle, set latency counter to 1, go to RUN.
REQ-013 RUN: latency counter SHALL increment each cycle; ap_done=1 with ap_continue=1 SHALL complete the transaction and return to IDLE; ap_done=1 with ap_continue=0 SHALL go to WAIT_CONT.
REQ-014 WAIT_CONT: latency and stall counters SHALL increment each cycle; ap_continue=1 SHALL complete the transaction and return to IDLE.
REQ-015 Latency SHALL equal cycles from start cycle through completion cycle inclusive (start and done in consecutive cycles -> 2).
REQ-016 Interval SHALL equal cycles between consecutive start cycles; 0 for the first transaction after reset.
REQ-017 A new start SHALL be detected no earlier than the cycle after completion (IDLE re-samples ap_start).
REQ-018 rec_id SHALL start at 0 after reset and increment by 1 per completed transaction, wrapping at 2^ID_W.
REQ-019 All counters SHALL saturate at all-ones, never wrap.
REQ-020 Completion SHALL push {id, latency, interval, stall, incomplete=0} into the FIFO; record SHALL be visible at rec_valid no later than the following cycle.
REQ-021 FIFO SHALL be first-word-fall-through; pop when rec_valid && rec_ready.
REQ-022 Push when full SHALL drop the record and increment overflow_cnt (saturating at 16'hFFFF); simultaneous push and pop when full SHALL succeed.
REQ-023 finish=1 in IDLE SHALL go to FLUSH; in RUN or WAIT_CONT SHALL push the in-flight record with incomplete=1 then go to FLUSH.
REQ-024 FLUSH SHALL ignore the handshake inputs and go to DONE when the FIFO is empty.
REQ-025 DONE SHALL assert drained=1 and hold until reset.
REQ-026 ap_done, ap_ready, ap_continue in IDLE SHALL be ignored.

Reset
REQ-027 ap_rst_n=0 SHALL, at the next rising edge, force IDLE, empty FIFO, and clear all counters, rec_id and overflow_cnt.
REQ-028 During and after reset: rec_valid=0, rec_incomplete=0, drained=0, all data outputs 0.
REQ-029 Reset mid-transaction SHALL discard the in-flight transaction without pushing a record.

Configuration
REQ-030 Macro PROFILER_STALL_EN defined: stall counter implemented per REQ-014.
REQ-031 PROFILER_STALL_EN undefined: no stall counter; rec_stall SHALL be constant 0; WAIT_CONT and latency behaviour unchanged.

Verification
REQ-032 Start at cycle 10, done+continue at cycle 14 -> record id=0, latency=5, interval=0, stall=0.
REQ-033 Second start at cycle 20, done at 22 with continue=0, continue=1 at 25 -> id=1, latency=6, interval=10, stall=3 (stall=0 without PROFILER_STALL_EN).
REQ-034 rec_ready=0, 6 transactions with FIFO_DEPTH=4 -> 4 records retained (ids 0-3), overflow_cnt=2, then rec_ready=1 drains ids 0-3 in order.
REQ-035 finish asserted 3 cycles after a start with no done -> record incomplete=1, latency=4, then drained=1 after sink pops it.
REQ-036 ap_rst_n=0 for one cycle while in RUN with 2 records queued -> rec_valid=0, overflow_cnt=0, next record id=0, interval=0.
REQ-037 Hold ap_start high for 300 cycles with CNT_W=8, done never asserted, then finish -> rec_latency=8'hFF, incomplete=1.
